// File: rtl/core_s1_pkg.sv
// Shared types for the LETC fetch stage: instruction word, fetch entry, reset PC.
package core_s1_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instruction;
    word_t pc;
    word_t next_seq_pc;
    logic  fault;
  } fetch_entry_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_s1_if.sv
// Fetch-stage bus bundle: icache request/response, s2 handshake, redirect and halt.
interface core_s1_if;

  logic                icache_req_valid;
  logic                icache_req_ready;
  core_s1_pkg::word_t  icache_req_addr;
  logic                icache_rsp_valid;
  core_s1_pkg::word_t  icache_rsp_data;
  logic                icache_rsp_fault;

  logic                s2_valid;
  logic                s2_ready;
  core_s1_pkg::word_t  s2_instruction;
  core_s1_pkg::word_t  s2_pc;
  core_s1_pkg::word_t  s2_next_seq_pc;
  logic                s2_fetch_fault;

  logic                redirect_valid;
  core_s1_pkg::word_t  redirect_pc;
  logic                halt_req;

  // master = the fetch stage itself
  modport master (
    output icache_req_valid, icache_req_addr,
    input  icache_req_ready, icache_rsp_valid, icache_rsp_data, icache_rsp_fault,
    output s2_valid, s2_instruction, s2_pc, s2_next_seq_pc, s2_fetch_fault,
    input  s2_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  icache_req_valid, icache_req_addr,
    output icache_req_ready, icache_rsp_valid, icache_rsp_data, icache_rsp_fault,
    input  s2_valid, s2_instruction, s2_pc, s2_next_seq_pc, s2_fetch_fault,
    output s2_ready, redirect_valid, redirect_pc, halt_req
  );

endinterface

// File: rtl/core_s1_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
module core_s1_fifo
  import core_s1_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == AW'(gi))) begin
          mem_q[gi] <= data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Head is forced to zero when empty so s2 never sees stale data.
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/core_s1.sv
// LETC fetch stage: owns the PC, issues credit-limited icache requests, buffers
// responses for core_s2 and discards responses made stale by a redirect.
module core_s1
  import core_s1_pkg::*;
#(
  parameter word_t RESET_PC   = RESET_PC_DEFAULT,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  core_s1_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  word_t         pc_q, pc_d;
  word_t         resp_pc_q, resp_pc_d;
  word_t         redirect_target;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          req_valid, req_hs, push, pop;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  push_entry, head_entry;

  assign redirect_target = word_align(bus.redirect_pc);

  // In-flight plus buffered entries never exceed the FIFO depth, so pushes cannot overflow.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req_valid   = !rst && !bus.halt_req && !bus.redirect_valid &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign req_hs      = req_valid && bus.icache_req_ready;
  assign push        = bus.icache_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
  assign pop         = !fifo_empty && bus.s2_ready && !bus.redirect_valid;

  assign push_entry = '{instruction: bus.icache_rsp_data,
                        pc:          resp_pc_q,
                        next_seq_pc: resp_pc_q + 32'd4,
                        fault:       bus.icache_rsp_fault};

  core_s1_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(bus.icache_rsp_valid);
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d      = redirect_target;
      resp_pc_d = redirect_target;
      drop_d    = outstanding_q - CW'(bus.icache_rsp_valid);
    end else begin
      if (req_hs) pc_d = pc_q + 32'd4;
      if (push) resp_pc_d = resp_pc_q + 32'd4;
      if (bus.icache_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && fifo_full));
    end
  end

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_addr  = pc_q;
  assign bus.s2_valid         = !fifo_empty;
  assign bus.s2_instruction   = head_entry.instruction;
  assign bus.s2_pc            = head_entry.pc;
  assign bus.s2_next_seq_pc   = head_entry.next_seq_pc;
  assign bus.s2_fetch_fault   = head_entry.fault;

endmodule

// File: tb/tb_core_s1.sv
// Fetch-stage bench: icache model plus a transaction-level reference of the s2 stream.
module tb_core_s1;
  import core_s1_pkg::*;

  localparam int    DEPTH = 2;
  localparam word_t RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_s1_if bus ();

  core_s1 #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    word_t addr;
    logic  stale;
    int    due;
    logic  fault;
  } req_t;

  req_t         inflight[$];
  fetch_entry_t expq[$];
  word_t        req_log[$];
  word_t        pop_log[$];
  word_t        fetch_pc;
  int           cyc, last_due, first_valid;
  int           n_checks = 0;
  int           n_fail   = 0;

  int    lat_min, lat_max, req_rdy_pct, s2_rdy_pct, fault_pct;
  logic  halt_k, redir_now, rand_mode;
  word_t redir_pc_now;

  function automatic word_t mem_word(input word_t a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step();
    logic rv, hs, rsp, pop;
    int   lat, due;
    req_t r;
    cyc++;
    if (rand_mode) begin
      halt_k       = ($urandom_range(9) == 0);
      redir_now    = ($urandom_range(19) == 0);
      redir_pc_now = $urandom;
    end
    bus.halt_req         = halt_k;
    bus.redirect_valid   = redir_now;
    bus.redirect_pc      = redir_pc_now;
    bus.icache_req_ready = ($urandom_range(99) < req_rdy_pct);
    bus.s2_ready         = ($urandom_range(99) < s2_rdy_pct);
    rsp = (inflight.size() > 0) && (inflight[0].due <= cyc);
    bus.icache_rsp_valid = rsp;
    bus.icache_rsp_data  = rsp ? mem_word(inflight[0].addr) : $urandom;
    bus.icache_rsp_fault = rsp ? inflight[0].fault : 1'b0;
    #4;
    rv = !halt_k && !redir_now && ((inflight.size() + expq.size()) < DEPTH);
    chk("req_valid", {31'b0, bus.icache_req_valid}, {31'b0, rv});
    if (rv) chk("req_addr", bus.icache_req_addr, fetch_pc);
    chk("s2_valid", {31'b0, bus.s2_valid}, {31'b0, (expq.size() > 0)});
    if (expq.size() > 0) begin
      chk("s2_instruction", bus.s2_instruction, expq[0].instruction);
      chk("s2_pc", bus.s2_pc, expq[0].pc);
      chk("s2_next_seq_pc", bus.s2_next_seq_pc, expq[0].next_seq_pc);
      chk("s2_fetch_fault", {31'b0, bus.s2_fetch_fault}, {31'b0, expq[0].fault});
    end
    if (bus.s2_valid && first_valid < 0) first_valid = cyc;
    hs  = bus.icache_req_valid && bus.icache_req_ready;
    pop = bus.s2_valid && bus.s2_ready && !redir_now;
    if (pop && expq.size() > 0) begin
      $display("[%0t] s2 take pc=%h instr=%h fault=%0b", $time, bus.s2_pc, bus.s2_instruction, bus.s2_fetch_fault);
      pop_log.push_back(expq[0].pc);
      void'(expq.pop_front());
    end
    if (rsp) begin
      r = inflight.pop_front();
      if (!r.stale && !redir_now)
        expq.push_back('{mem_word(r.addr), r.addr, r.addr + 32'd4, r.fault});
    end
    if (redir_now) begin
      $display("[%0t] redirect to %h", $time, redir_pc_now);
      expq.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fetch_pc = {redir_pc_now[31:2], 2'b00};
    end else if (hs) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      inflight.push_back('{fetch_pc, 1'b0, due, ($urandom_range(99) < fault_pct)});
      req_log.push_back(fetch_pc);
      $display("[%0t] icache req addr=%h", $time, fetch_pc);
      fetch_pc += 32'd4;
    end
    redir_now = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.icache_rsp_valid = 1'b0;
    bus.icache_rsp_data  = '0;
    bus.icache_rsp_fault = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = '0;
    bus.halt_req         = 1'b0;
    bus.s2_ready         = 1'b0;
    bus.icache_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, bus.icache_req_valid}, 32'd0);
    chk("rst_req_addr", bus.icache_req_addr, RPC);
    chk("rst_s2_valid", {31'b0, bus.s2_valid}, 32'd0);
    chk("rst_s2_instruction", bus.s2_instruction, 32'd0);
    chk("rst_s2_pc", bus.s2_pc, 32'd0);
    chk("rst_s2_next_seq_pc", bus.s2_next_seq_pc, 32'd0);
    chk("rst_s2_fetch_fault", {31'b0, bus.s2_fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    inflight.delete();
    expq.delete();
    req_log.delete();
    pop_log.delete();
    fetch_pc    = RPC;
    cyc         = -1;
    last_due    = -1;
    first_valid = -1;
    halt_k      = 1'b0;
    redir_now   = 1'b0;
  endtask

  initial begin
    int n, guard;
    rand_mode = 1'b0; fault_pct = 0; lat_min = 1; lat_max = 1;
    req_rdy_pct = 100; s2_rdy_pct = 100; redir_pc_now = '0;

    // 1: streaming with a 1-cycle icache
    do_reset();
    repeat (12) step();
    chk("first_s2_valid_cycle", first_valid, 32'd2);
    chk("stream_pop0", pop_log[0], 32'h0);
    chk("stream_pop1", pop_log[1], 32'h4);

    // 2: s2 stalls, credit caps requests at DEPTH
    do_reset();
    s2_rdy_pct = 0;
    repeat (10) step();
    chk("stall_req_count", req_log.size(), DEPTH);
    s2_rdy_pct = 100;
    repeat (6) step();
    chk("drain_pop0", pop_log[0], 32'h0);
    chk("drain_pop1", pop_log[1], 32'h4);
    chk("resume_req", req_log[DEPTH], 32'h8);

    // 3: redirect with two stale requests in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    guard = 0;
    while (inflight.size() < 2 && guard < 20) begin step(); guard++; end
    chk("two_outstanding_reached", inflight.size(), 32'd2);
    pop_log.delete();
    redir_now = 1'b1; redir_pc_now = 32'h100;
    step();
    repeat (12) step();
    chk("redirect_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

    // 4: redirect coinciding with a response and an s2 take
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    guard = 0;
    while (!(expq.size() > 0 && inflight.size() > 0 && inflight[0].due <= cyc + 1) && guard < 20) begin
      step(); guard++;
    end
    req_log.delete();
    redir_now = 1'b1; redir_pc_now = 32'h203;
    step();
    chk("flush_s2_valid", {31'b0, bus.s2_valid}, 32'd0);
    repeat (6) step();
    chk("redirect_fetch_addr", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h200);

    // 5: PC wrap at the top of the address space; back-to-back redirects
    redir_now = 1'b1; redir_pc_now = 32'h4000;
    step();
    req_log.delete();
    redir_now = 1'b1; redir_pc_now = 32'hFFFF_FFF8;
    step();
    repeat (8) step();
    chk("wrap_req0", req_log[0], 32'hFFFF_FFF8);
    chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
    chk("wrap_req2", req_log[2], 32'h0);

    // 6: halt with one outstanding, then faults and random traffic, then mid-stream reset
    do_reset();
    lat_min = 3; lat_max = 3;
    step();
    halt_k = 1'b1;
    n = req_log.size();
    repeat (5) step();
    chk("halt_no_new_reqs", req_log.size(), n);
    chk("halt_rsp_delivered", pop_log.size(), 32'd1);
    halt_k = 1'b0;
    fault_pct = 30; lat_min = 1; lat_max = 4; req_rdy_pct = 70; s2_rdy_pct = 60;
    rand_mode = 1'b1;
    repeat (400) step();
    do_reset();
    rand_mode = 1'b0; fault_pct = 0; lat_min = 1; lat_max = 1;
    req_rdy_pct = 100; s2_rdy_pct = 100;
    repeat (8) step();
    chk("refetch_after_reset", req_log[0], RPC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
